// File: rtl/line_mem_ctrl.sv
// line_mem_ctrl: serialises one 128-bit cache line read or write into four
// 32-bit beats on a single-port synchronous word RAM, with a fixed pre-access latency.
module line_mem_ctrl #(
  parameter int WIDTH         = 32,
  parameter int MEM_ADDR_BITS = 17,
  parameter int LATENCY       = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_req,
  input  logic                     WriteEnable,
  input  logic [31:0]              memory_address,
  input  logic [4*WIDTH-1:0]       mem_writedata,
  output logic [4*WIDTH-1:0]       mem_readdata,
  output logic                     mem_ready,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic [MEM_ADDR_BITS-3:0] ram_addr,
  output logic [WIDTH-1:0]         ram_wdata,
  input  logic [WIDTH-1:0]         ram_rdata
);

  localparam int         LINE_BITS = MEM_ADDR_BITS - 4;
  localparam logic [3:0] WAIT_LAST = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [2:0] {IDLE, WAIT, RD, RD_TAIL, WR, DONE} state_t;

  state_t               state;
  logic [LINE_BITS-1:0] line_base;
  logic                 is_write;
  logic [4*WIDTH-1:0]   wr_line;
  logic [4*WIDTH-1:0]   line_buf;
  logic [1:0]           beat;
  logic [3:0]           wait_cnt;

  logic [LINE_BITS-1:0] src_base;
  logic                 src_write;
  logic [4*WIDTH-1:0]   src_line;
  logic [1:0]           issue_num;
  logic [1:0]           prev_beat;
  logic [WIDTH-1:0]     issue_word;
  logic                 launch;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^{memory_address[31:MEM_ADDR_BITS], memory_address[3:0]};
  assign mem_readdata     = line_buf;
  assign prev_beat        = beat - 2'd1;

  // With zero latency the first beat leaves straight from IDLE, so it must
  // use the live request fields instead of the not-yet-latched copies.
  always_comb begin
    src_base  = line_base;
    src_write = is_write;
    src_line  = wr_line;
    if (state == IDLE) begin
      src_base  = memory_address[MEM_ADDR_BITS-1:4];
      src_write = WriteEnable;
      src_line  = mem_writedata;
    end
    issue_num  = ((state == RD) || (state == WR)) ? beat + 2'd1 : 2'd0;
    issue_word = src_line[issue_num*WIDTH +: WIDTH];
    launch     = ((state == IDLE) && mem_req && (LATENCY == 0)) ||
                 ((state == WAIT) && (wait_cnt == WAIT_LAST)) ||
                 (((state == RD) || (state == WR)) && (beat != 2'd3));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      line_base <= '0;
      is_write  <= 1'b0;
      wr_line   <= '0;
      line_buf  <= '0;
      beat      <= 2'd0;
      wait_cnt  <= 4'd0;
      mem_ready <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req) begin
            line_base <= src_base;
            is_write  <= WriteEnable;
            if (WriteEnable) wr_line <= mem_writedata;
            beat      <= 2'd0;
            wait_cnt  <= 4'd0;
            if (LATENCY > 0) state <= WAIT;
            else             state <= WriteEnable ? WR : RD;
          end
        end
        WAIT: begin
          if (wait_cnt == WAIT_LAST) state <= is_write ? WR : RD;
          else                       wait_cnt <= wait_cnt + 4'd1;
        end
        RD: begin
          // The RAM answers one cycle late, so each beat stores its predecessor.
          if (beat != 2'd0) line_buf[prev_beat*WIDTH +: WIDTH] <= ram_rdata;
          if (beat == 2'd3) state <= RD_TAIL;
          else              beat  <= beat + 2'd1;
        end
        RD_TAIL: begin
          line_buf[3*WIDTH +: WIDTH] <= ram_rdata;
          state     <= DONE;
          mem_ready <= 1'b1;
        end
        WR: begin
          if (beat == 2'd3) begin
            state     <= DONE;
            mem_ready <= 1'b1;
          end else begin
            beat <= beat + 2'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (launch) begin
        ram_en   <= 1'b1;
        ram_we   <= src_write;
        ram_addr <= {src_base, issue_num};
        if (src_write) ram_wdata <= issue_word;
      end
    end
  end

endmodule
